uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serial UART transmitter; the line-side counterpart of the team's UART receiver. It accepts bytes from the core over a valid/ready handshake and drives a single `tx` line. The frame format is start bit, 8 data bits LSB-first, odd parity bit, stop bit. That is the exact format the receiver checks, so `tx` can be looped back into it.

## Interface
- `CLK_FREQ`, default 30_000_000: clock frequency in Hz.
- `BAUD`, default 9600: bit rate in Hz.
  - DIVIDER = CLK_FREQ/BAUD, integer division.
  - DIVIDER must be ≥ 2.
- `FIFO_DEPTH`, default 4: input FIFO entries.
  - Power of two, ≥ 2.
  - Used only with `UART_TX_FIFO_EN`.
- `clk` in 1: single system clock. All logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tx_data` in 8: byte to send. Sampled on handshake.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: block can accept a byte this cycle.
- `tx` out 1: serial line, registered, idles high.
- `busy` out 1: a frame is on the line (START..STOP).
- `done` out 1: one-cycle pulse at the end of each stop bit.

## Operation
- Handshake:
  - A transfer occurs on a rising edge where `tx_valid && tx_ready`.
  - `tx_data` must be stable only at that edge.
  - `tx_valid` high while `tx_ready` is low has no effect; nothing is dropped or latched.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1.
  - IDLE → START on a byte becoming available. The byte loads into the shift register and the odd parity bit is computed as parity = ~^byte.
  - START: `tx`=0 for DIVIDER cycles → DATA.
  - DATA: `tx`=shift[0]. The register shifts right every DIVIDER cycles. After 8 bits → PARITY.
  - PARITY: `tx`=parity for DIVIDER cycles → STOP.
  - STOP: `tx`=1 for DIVIDER cycles. At the final cycle, `done` pulses, then:
    - go to START directly if a byte is pending (FIFO build only);
    - otherwise go to IDLE.
- Bit counter: 3-bit data index.
- Baud counter: width $clog2(DIVIDER)+1, counting 0..DIVIDER-1. It is cleared on every state change. There is no half-bit phase: all bits are full length.
- `busy` = state ≠ IDLE.
- The input is never modified mid-frame; the shift register is private.
- Reset asserted mid-frame, asynchronously:
  - `tx`=1 immediately; the partial frame is abandoned.
  - State → IDLE; counters → 0; FIFO emptied.
  - `done`=0, `busy`=0.
  - No transfer is accepted while `rst_n`=0.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0. `tx_ready`=1 in the first cycle after release.
- Frame length: 11×DIVIDER cycles, measured from the first cycle of `tx`=0 to the end of stop.
- Without the FIFO:
  - `tx` falls at the accepting edge (latency 0 cycles after the handshake edge).
  - The next accept is possible no earlier than the edge after STOP ends. The stop bit is therefore ≥ DIVIDER+1 cycles between frames.
- With the FIFO:
  - A byte pushed into an empty FIFO in IDLE starts at the next edge (latency 1).
  - Back-to-back frames have zero extra idle cycles.
- `done` is high exactly 1 cycle per frame. It is coincident with the last stop-bit cycle.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - A FIFO_DEPTH × 8 FIFO sits in front of the FSM; `tx_ready` = !full.
  - Simultaneous push and pop is allowed at any fill level except push-when-full. Push-when-full is impossible because `tx_ready`=0.
  - Push into empty plus pop in the same cycle does not happen; pop only sees stored entries.
  - Order is strictly FIFO.
- `UART_TX_FIFO_EN` not defined:
  - A single holding path; `tx_ready` = (state==IDLE).
  - No storage beyond the shift register.

## Test plan
Use CLK_FREQ=16, BAUD=1 (DIVIDER=16) unless stated.
- Send 0xA5 → `tx` shows 0, then 1,0,1,0,0,1,0,1, then parity 1, then stop 1. Each level lasts 16 cycles; `done` pulses once at cycle 176.
- Send 0x07 → parity bit 0. Send 0x00 → parity bit 1. Send 0xFF → parity bit 1.
- Hold `tx_valid`=1 with 0x11 while `busy`=1 (non-FIFO build) → no accept until after `done`. 0x11 is sent exactly once.
- FIFO build: push 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles:
  - `tx_ready` drops after four pushes held in the FIFO;
  - frames are contiguous with no idle gap;
  - output order is 01..05;
  - 5 `done` pulses.
- Assert `rst_n`=0 in the middle of bit 3 of 0x3C → `tx`=1 within the same cycle and `busy`=0. After release, 0x5A is sent cleanly.
- Loop `tx` into the team's receiver at 30 MHz/9600 and send 0x00, 0x55, 0xAA, 0xFF → the receiver reports the same bytes with valid=1.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB-first, odd parity, one stop bit.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH x 8 FIFO in front of the frame FSM.
module uart_tx #(
  parameter int CLK_FREQ   = 30_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int DIVIDER = CLK_FREQ / BAUD;
  localparam int CNT_W   = $clog2(DIVIDER) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);

  if (DIVIDER < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx: DIVIDER must be >= 2 and FIFO_DEPTH a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nx;
  logic [2:0]       bit_cnt, bit_cnt_nx;
  logic [7:0]       shift, shift_nx;
  logic             parity, parity_nx;
  logic             tx_nx;
  logic             bit_end;
  logic             load;
  logic             avail;
  logic [7:0]       avail_data;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit CHAIN = 1'b1;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_ready   = !full;
  assign push       = tx_valid && tx_ready;
  assign avail      = !empty;
  assign avail_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end
`else
  localparam bit CHAIN = 1'b0;

  assign tx_ready   = (state == S_IDLE);
  assign avail      = tx_valid;
  assign avail_data = tx_data;
`endif

  assign bit_end = (baud_cnt == CNT_LAST);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx    = state;
    baud_cnt_nx = bit_end ? '0 : baud_cnt + 1'b1;
    bit_cnt_nx  = bit_cnt;
    shift_nx    = shift;
    parity_nx   = parity;
    load        = 1'b0;

    case (state)
      S_IDLE: begin
        baud_cnt_nx = '0;
        if (avail) begin
          load     = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: if (bit_end) state_nx = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_nx = S_PARITY;
          end else begin
            shift_nx   = {1'b0, shift[7:1]};
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
      S_PARITY: if (bit_end) state_nx = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (CHAIN && avail) begin
            load     = 1'b1;
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (load) begin
      shift_nx   = avail_data;
      parity_nx  = ~^avail_data;
      bit_cnt_nx = '0;
    end
    if (state_nx != state) baud_cnt_nx = '0;

    // tx is registered from the next state so the line changes on the same edge as the FSM.
    case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = shift_nx[0];
      S_PARITY: tx_nx = parity_nx;
      default:  tx_nx = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shift    <= shift_nx;
      parity   <= parity_nx;
      tx       <= tx_nx;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at DIVIDER=16: stimulus queues expected frames,
// a line monitor decodes tx cycle by cycle and compares each completed frame.
module tb_uart_tx;

  localparam int DIV   = 16;
  localparam int FRAME = 11 * DIV;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy, done;

  uart_tx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = -1;
  int   frames_ok = 0;
  int   frames_abort = 0;
  exp_t exp_q[$];
  int   start_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at the negedge of the first start-bit cycle; samples all 11 bit slots.
  task automatic decode_frame();
    logic [10:0] lvl = '1;
    bit          stable_ok = 1'b1;
    bit          done_ok = 1'b1;
    bit          busy_ok = 1'b1;
    bit          aborted = 1'b0;
    exp_t        e;
    start_q.push_back(cyc);
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < DIV; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!rst_n) begin
          aborted = 1'b1;
          break;
        end
        if (c == 0) lvl[b] = tx;
        else if (tx !== lvl[b]) stable_ok = 1'b0;
        if (done !== ((b == 10 && c == DIV - 1) ? 1'b1 : 1'b0)) done_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
      if (aborted) break;
    end
    if (aborted) begin
      frames_abort++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      return;
    end
    frames_ok++;
    check("frame_expected", (exp_q.size() > 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("start_bit", lvl[0], 0);
    check("frame_data", lvl[8:1], e.data);
    check("parity_bit", lvl[9], e.par);
    check("stop_bit", lvl[10], 1);
    check("bit_length", stable_ok, 1);
    check("done_position", done_ok, 1);
    check("busy_in_frame", busy_ok, 1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) decode_frame();
    end
  end

  // Entered at a negedge; returns at the negedge after the accepting edge with tx_valid low.
  task automatic push_byte(input logic [7:0] b, input logic par, output int waited, output int acc_cyc);
    tx_data  = b;
    tx_valid = 1'b1;
    waited   = 0;
    acc_cyc  = -1;
    while (tx_ready !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      check("accept_timeout", tx_ready, 1);
      tx_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    exp_q.push_back('{data: b, par: par});
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int w, a, d0, n0, stalls, k;
`ifdef UART_TX_FIFO_EN
    logic [7:0] burst_d [5];
    logic       burst_p [5];
    burst_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    burst_p = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", tx_ready, 1);
    check("tx_idle_high", tx, 1);

    d0 = done_cnt;
    push_byte(8'hA5, 1'b1, w, a);
`ifdef UART_TX_FIFO_EN
    check("fifo_latency_idle", tx, 1);
    @(negedge clk);
    check("fifo_latency_start", tx, 0);
`else
    check("start_latency0", tx, 0);
    check("busy_at_start", busy, 1);
`endif
    wait_idle();
    check("done_once_a5", done_cnt - d0, 1);

    push_byte(8'h07, 1'b0, w, a); wait_idle();
    push_byte(8'h00, 1'b1, w, a); wait_idle();
    push_byte(8'hFF, 1'b1, w, a); wait_idle();

`ifdef UART_TX_FIFO_EN
    d0 = done_cnt;
    n0 = start_q.size();
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      push_byte(burst_d[i], burst_p[i], w, a);
      stalls += w;
    end
    check("burst_no_stall", stalls, 0);
    check("ready_low_when_full", tx_ready, 0);
    wait_idle();
    check("burst_done_pulses", done_cnt - d0, 5);
    check("burst_frames", start_q.size() - n0, 5);
    if (start_q.size() >= n0 + 5) begin
      for (int i = 1; i < 5; i++) check("frames_contiguous", start_q[n0 + i] - start_q[n0 + i - 1], FRAME);
    end
`else
    push_byte(8'h22, 1'b1, w, a);
    push_byte(8'h11, 1'b1, w, a);
    check("hold_stalled", (w > 0), 1);
    check("hold_accept_after_done", a, last_done_cyc + 1);
    wait_idle();
`endif

    // Reset in the middle of data bit 3 (bit slot 4) of 0x3C.
    push_byte(8'h3C, 1'b1, w, a);
    k = 0;
    while (tx !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("frame_3c_started", tx, 0);
    repeat (4 * DIV + DIV / 2 - 1) @(negedge clk);
    check("busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_tx_high", tx, 1);
    check("reset_busy_low", busy, 0);
    check("reset_done_low", done, 0);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("tx_held_in_reset", tx, 1);
    tx_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("no_accept_in_reset", busy, 0);
    check("ready_after_rerst", tx_ready, 1);
    check("frames_aborted", frames_abort, 1);

    push_byte(8'h5A, 1'b1, w, a);
    wait_idle();

`ifdef UART_TX_FIFO_EN
    check("frames_total", frames_ok, 10);
    check("done_total", done_cnt, 10);
`else
    check("frames_total", frames_ok, 7);
    check("done_total", done_cnt, 7);
`endif
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
